mips_control_fsm: RTL and testbench

Multi-cycle MIPS control unit: the producer of the 4-bit `ALUOp` code and datapath strobes that the clocked ALU consumes. It decodes `opcode`/`funct` from the instruction register and sequences FETCH → DECODE → EXECUTE → MEMORY → WRITEBACK. It drives `ALUOp` on the rising edge so the code is stable when the ALU samples on the falling edge. It consumes the ALU `zero` flag for branches.

---
 rtl/mips_ctrl_pkg.sv | 20 ++
 rtl/mips_control_fsm_alu_op_decode.sv | 42 ++++
 rtl/mips_control_fsm.sv | 90 +++++++++
 tb/tb_mips_control_fsm.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS control unit
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    ALU_NONE = 4'd0, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25,
                         FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLL = 6'h00, FN_SRL = 6'h02,
                         FN_SRA = 6'h03;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_BRANCH, S_WRITEBACK
  } state_t;
  typedef enum logic [2:0] {C_ILL, C_R, C_LW, C_SW, C_ADDI, C_BEQ, C_J} op_class_t;
  typedef struct packed {
    alu_op_t alu_op;
    logic    pc_write, ir_write, reg_write, mem_read, mem_write;
    logic    alu_src_imm, reg_dst_rd, mem_to_reg, branch_taken, jump, illegal, busy;
  } ctrl_t;
endpackage

// File: rtl/mips_control_fsm_alu_op_decode.sv
// alu_op_decode: combinational opcode/funct to instruction class, ALUOp and legality
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] cls_o,
  output logic [3:0] alu_op_o,
  output logic       legal_o
);
  alu_op_t   fn_op;
  op_class_t cls;
  always_comb begin
    fn_op = ALU_NONE;
    case (funct_i)
      FN_ADD:  fn_op = ALU_ADD;
      FN_SUB:  fn_op = ALU_SUB;
      FN_AND:  fn_op = ALU_AND;
      FN_OR:   fn_op = ALU_OR;
      FN_NOR:  fn_op = ALU_NOR;
      FN_SLT:  fn_op = ALU_SLT;
      FN_SLL:  fn_op = ALU_SLL;
      FN_SRL:  fn_op = ALU_SRL;
      FN_SRA:  fn_op = ALU_SRA;
      default: fn_op = ALU_NONE;
    endcase
    cls = C_ILL;
    case (opcode_i)
      OP_RTYPE: cls = fn_op != ALU_NONE ? C_R : C_ILL;
      OP_LW:    cls = C_LW;
      OP_SW:    cls = C_SW;
      OP_ADDI:  cls = C_ADDI;
      OP_BEQ:   cls = C_BEQ;
      OP_J:     cls = C_J;
      default:  cls = C_ILL;
    endcase
  end
  assign cls_o    = cls;
  assign legal_o  = cls != C_ILL;
  assign alu_op_o = cls == C_R ? fn_op : cls == C_BEQ ? ALU_SUB :
                    (cls == C_LW || cls == C_SW || cls == C_ADDI) ? ALU_ADD : ALU_NONE;
endmodule

// File: rtl/mips_control_fsm.sv
// mips_control_fsm: multi-cycle MIPS sequencer; every output is registered from the next state
// and the latched op, so ALUOp only moves on rising edges ahead of the ALU's falling-edge sample.
module mips_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] ALUOp,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src_imm,
  output logic       reg_dst_rd,
  output logic       mem_to_reg,
  output logic       branch_taken,
  output logic       jump,
  output logic       illegal,
  output logic       busy
);
  logic [2:0] dec_cls;
  logic [3:0] dec_alu;
  logic       dec_legal, in_dec, jmp, brt;
  state_t     state_q, state_d;
  op_class_t  cls_q, cls_d;
  alu_op_t    alu_q, alu_d;
  ctrl_t      ctrl_q, ctrl_d;
  alu_op_decode u_dec (
    .opcode_i(opcode),
    .funct_i (funct),
    .cls_o   (dec_cls),
    .alu_op_o(dec_alu),
    .legal_o (dec_legal)
  );
  always_comb begin
    in_dec  = state_q == S_DECODE;
    cls_d   = in_dec ? op_class_t'(dec_cls) : cls_q;
    alu_d   = in_dec ? alu_op_t'(dec_alu) : alu_q;
    jmp     = in_dec && cls_d == C_J;
    brt     = state_q == S_EXECUTE && cls_q == C_BEQ && zero;
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = (jmp || !dec_legal) ? (run ? S_FETCH : S_IDLE) : S_EXECUTE;
      S_EXECUTE:   state_d = (cls_q == C_LW || cls_q == C_SW) ? S_MEMORY :
                             cls_q == C_BEQ ? S_BRANCH : S_WRITEBACK;
      S_MEMORY:    state_d = !mem_ready ? S_MEMORY : cls_q == C_LW ? S_WRITEBACK :
                             run ? S_FETCH : S_IDLE;
      S_BRANCH:    state_d = S_FETCH;
      S_WRITEBACK: state_d = run ? S_FETCH : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    ctrl_d              = '0;
    ctrl_d.alu_op       = state_d == S_FETCH ? ALU_ADD : state_d == S_EXECUTE ? alu_d : ALU_NONE;
    ctrl_d.ir_write     = state_d == S_FETCH;
    ctrl_d.pc_write     = state_d == S_FETCH || jmp || brt;
    ctrl_d.reg_write    = state_d == S_WRITEBACK;
    ctrl_d.mem_read     = state_d == S_MEMORY && cls_d == C_LW;
    ctrl_d.mem_write    = state_d == S_MEMORY && cls_d == C_SW;
    ctrl_d.alu_src_imm  = state_d == S_EXECUTE && (cls_d == C_LW || cls_d == C_SW || cls_d == C_ADDI);
    ctrl_d.reg_dst_rd   = state_d == S_EXECUTE && cls_d == C_R;
    ctrl_d.mem_to_reg   = state_d == S_WRITEBACK && cls_d == C_LW;
    ctrl_d.branch_taken = brt;
    ctrl_d.jump         = jmp;
    ctrl_d.illegal      = in_dec && !dec_legal;
    ctrl_d.busy         = state_d != S_IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_ILL;
      alu_q   <= ALU_NONE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      ctrl_q  <= ctrl_d;
    end
  end
  assign {ALUOp, pc_write, ir_write, reg_write, mem_read, mem_write, alu_src_imm, reg_dst_rd,
          mem_to_reg, branch_taken, jump, illegal, busy} = ctrl_q;
endmodule

// File: tb/tb_mips_control_fsm.sv
// tb_mips_control_fsm: random instruction stream checked cycle by cycle against per-instruction
// expected output traces built from the instruction-level timing rules.
module tb_mips_control_fsm;
  logic clock = 1'b0, reset_n = 1'b0, run = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [3:0] ALUOp;
  logic pc_write, ir_write, reg_write, mem_read, mem_write, alu_src_imm, reg_dst_rd;
  logic mem_to_reg, branch_taken, jump, illegal, busy;

  mips_control_fsm dut (
    .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .ALUOp(ALUOp), .pc_write(pc_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src_imm(alu_src_imm), .reg_dst_rd(reg_dst_rd), .mem_to_reg(mem_to_reg),
    .branch_taken(branch_taken), .jump(jump), .illegal(illegal), .busy(busy)
  );

  always #5 clock = ~clock;

  wire [15:0] obs = {ALUOp, pc_write, ir_write, reg_write, mem_read, mem_write, alu_src_imm,
                     reg_dst_rd, mem_to_reg, branch_taken, jump, illegal, busy};

  localparam logic [15:0] PC = 16'h0800, IR = 16'h0400, RW = 16'h0200, MRD = 16'h0100,
                          MWR = 16'h0080, IMM = 16'h0040, RD = 16'h0020, M2R = 16'h0010,
                          BT = 16'h0008, JMP = 16'h0004, ILL = 16'h0002, BUSY = 16'h0001;
  logic [5:0] fmap [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};

  typedef struct {
    string       tag;
    logic [15:0] e;
    logic        rn, zr, mr;
    logic [5:0]  op, fn;
  } step_t;
  step_t plan [$];
  logic [15:0] pend = '0;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [15:0] a(input logic [3:0] op);
    return {op, 12'h000};
  endfunction

  task automatic add(input string tag, input logic [15:0] e, input logic rn, input logic zr,
                     input logic mr);
    step_t s;
    s.tag = tag; s.e = e; s.rn = rn; s.zr = zr; s.mr = mr;
    s.op = 6'($urandom); s.fn = 6'($urandom);
    plan.push_back(s);
  endtask

  // after an instruction ends with run low: IDLE cycles, the last one raising run
  task automatic fin(input logic r);
    int m;
    if (!r) begin
      m = $urandom_range(0, 2);
      for (int i = 0; i <= m; i++) begin
        add("IDLE", pend, i == m, rb(), rb());
        pend = '0;
      end
    end
  endtask

  // expected trace of one instruction, starting at its FETCH cycle
  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input int n, input logic z,
                     input logic r);
    int fi = -1;
    logic lw;
    for (int i = 0; i < 9; i++) if (fmap[i] == fn) fi = i;
    add("FETCH", pend | a(4'd1) | PC | IR | BUSY, rb(), rb(), rb());
    pend = '0;
    add("DECODE", BUSY, r, rb(), rb());
    plan[$].op = op;
    plan[$].fn = fn;
    if (op == 6'h00 && fi >= 0) begin
      add("R.EX", a(4'(fi + 1)) | RD | BUSY, rb(), rb(), rb());
      add("R.WB", RW | BUSY, r, rb(), rb());
      fin(r);
    end else if (op == 6'h08) begin
      add("ADDI.EX", a(4'd1) | IMM | BUSY, rb(), rb(), rb());
      add("ADDI.WB", RW | BUSY, r, rb(), rb());
      fin(r);
    end else if (op == 6'h23 || op == 6'h2B) begin
      lw = op == 6'h23;
      add("MEM.EX", a(4'd1) | IMM | BUSY, rb(), rb(), rb());
      for (int i = 0; i <= n; i++)
        add(lw ? "LW.MEM" : "SW.MEM", (lw ? MRD : MWR) | BUSY, (!lw && i == n) ? r : rb(),
            rb(), i == n);
      if (lw) add("LW.WB", RW | M2R | BUSY, r, rb(), rb());
      fin(r);
    end else if (op == 6'h04) begin
      add("BEQ.EX", a(4'd2) | BUSY, rb(), z, rb());
      add("BEQ.BR", (z ? (BT | PC) : 16'h0) | BUSY, rb(), rb(), rb());
    end else begin
      pend = op == 6'h02 ? (JMP | PC) : ILL;
      fin(r);
    end
  endtask

  task automatic run_plan(input int cnt);
    step_t s;
    for (int i = 0; i < cnt && plan.size() > 0; i++) begin
      s = plan.pop_front();
      run = s.rn; zero = s.zr; mem_ready = s.mr; opcode = s.op; funct = s.fn;
      chk(s.tag, obs, s.e);
      @(negedge clock);
    end
  endtask

  initial begin
    logic [5:0] op, fn;
    int k;
    reset_n = 1'b0;
    run = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset", obs, 16'h0000);
    reset_n = 1'b1;
    @(negedge clock);
    gen(6'h00, 6'h22, 0, 1'b0, 1'b1);
    gen(6'h23, 6'h11, 3, 1'b0, 1'b1);
    gen(6'h04, 6'h00, 0, 1'b1, 1'b1);
    gen(6'h04, 6'h00, 0, 1'b0, 1'b1);
    gen(6'h3F, 6'h20, 0, 1'b0, 1'b1);
    gen(6'h00, 6'h01, 0, 1'b0, 1'b0);
    gen(6'h02, 6'h05, 0, 1'b0, 1'b0);
    run_plan(plan.size());
    for (int i = 0; i < 120; i++) begin
      k = $urandom_range(0, 7);
      fn = 6'($urandom);
      op = k == 0 ? 6'h00 : k == 1 ? 6'h00 : k == 2 ? 6'h23 : k == 3 ? 6'h2B :
           k == 4 ? 6'h08 : k == 5 ? 6'h04 : k == 6 ? 6'h02 : 6'($urandom);
      if (k == 0) fn = fmap[$urandom_range(0, 8)];
      gen(op, fn, $urandom_range(0, 4), rb(), $urandom_range(0, 3) != 0);
      run_plan(plan.size());
    end
    gen(6'h2B, 6'h00, 50, 1'b0, 1'b1);
    run_plan(plan.size() - 40);
    chk("sw.mem", obs, MWR | BUSY);
    reset_n = 1'b0;
    #1;
    chk("rst.async", obs, 16'h0000);
    plan.delete();
    pend = '0;
    run = 1'b0;
    @(negedge clock);
    chk("rst.hold", obs, 16'h0000);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst.idle", obs, 16'h0000);
    run = 1'b1;
    @(negedge clock);
    chk("rst.fetch", obs, a(4'd1) | PC | IR | BUSY);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
